// File: rtl/apb_slave_mem.sv
// APB completer: DEPTH-word register memory with programmable access-phase
// wait states and an error response for addresses at or above DEPTH.
module apb_slave_mem #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              latch, complete, finish;
  logic [ADDR_W-1:0] op_addr;
  logic              op_write;
  logic [DATA_W-1:0] op_wdata;
  logic              op_err;
  logic [IDX_W-1:0]  op_idx;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    latch    = 1'b0;
    complete = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          latch    = 1'b1;
          state_n  = ACCESS;
          cnt_n    = WAIT_INIT;
          complete = (WAIT_INIT == '0);
        end
      end
      ACCESS: begin
        if (pready) begin
          finish  = 1'b1;
          state_n = IDLE;
        end else if (!psel) begin
          state_n = IDLE;
        end else begin
          cnt_n    = cnt - 4'd1;
          complete = (cnt == 4'd1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Zero-wait completion happens on the setup edge, before the latches are loaded,
  // so the operation is taken straight from the bus while in IDLE.
  always_comb begin
    op_addr  = (state == IDLE) ? paddr  : addr_q;
    op_write = (state == IDLE) ? pwrite : write_q;
    op_wdata = (state == IDLE) ? pwdata : wdata_q;
    op_err   = ({1'b0, op_addr} >= DEPTH_LIM);
    op_idx   = op_addr[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      mem     <= '{default: '0};
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
      end
      if (complete) begin
        pready  <= 1'b1;
        pslverr <= op_err;
        if (op_err)
          prdata <= '0;
        else if (op_write)
          mem[op_idx] <= op_wdata;
        else
          prdata <= mem[op_idx];
      end else if (finish) begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
      end
    end
  end

endmodule
